// File: rtl/excp_commit_ctrl_pkg.sv
// Shared constants for the commit-stage exception arbiter: exception vector bit
// positions, ECODE/ESUBCODE values and the FSM state encoding.
package excp_commit_ctrl_pkg;

  localparam int EXCP_ADEF = 0;
  localparam int EXCP_INE  = 1;
  localparam int EXCP_IPE  = 2;
  localparam int EXCP_SYS  = 3;
  localparam int EXCP_BRK  = 4;
  localparam int EXCP_ALE  = 5;
  localparam int EXCP_ADEM = 6;
  localparam int EXCP_NUM  = 7;

  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;
  localparam logic [5:0] ECODE_SYS = 6'h0B;
  localparam logic [5:0] ECODE_BRK = 6'h0C;
  localparam logic [5:0] ECODE_INE = 6'h0D;
  localparam logic [5:0] ECODE_IPE = 6'h0E;

  localparam logic [8:0] ESUB_NONE = 9'd0;
  localparam logic [8:0] ESUB_ADEF = 9'd0;
  localparam logic [8:0] ESUB_ADEM = 9'd1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/excp_commit_ctrl_if.sv
// Commit-side and CSR-side signal bundle of the exception arbiter.
// Handshake: an instruction commits on a rising edge where wb_valid && wb_ready;
// wb_valid may be held while wb_ready is low and the retiring fields must stay stable.
interface excp_commit_ctrl_if
  import excp_commit_ctrl_pkg::*;
#(
  parameter int EXCP_W = 7
);
  logic              wb_valid;
  logic              wb_ready;
  logic [31:0]       wb_pc;
  logic [EXCP_W-1:0] wb_excp_vec;
  logic              wb_ertn;
  logic              has_int;
  logic [31:0]       csr_eentry;
  logic [31:0]       csr_era;
  logic              excp_flush;
  logic              ertn_flush;
  logic [31:0]       era_out;
  logic [5:0]        ecode_out;
  logic [8:0]        esubcode_out;
  logic              pipe_flush;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  state_t            dbg_state;

  modport master (
    output wb_valid, wb_pc, wb_excp_vec, wb_ertn, has_int, csr_eentry, csr_era,
    input  wb_ready, excp_flush, ertn_flush, era_out, ecode_out, esubcode_out,
           pipe_flush, redirect_valid, redirect_pc, dbg_state
  );

  modport slave (
    input  wb_valid, wb_pc, wb_excp_vec, wb_ertn, has_int, csr_eentry, csr_era,
    output wb_ready, excp_flush, ertn_flush, era_out, ecode_out, esubcode_out,
           pipe_flush, redirect_valid, redirect_pc, dbg_state
  );

endinterface

// File: rtl/excp_prio_enc.sv
// Combinational event priority encoder: interrupt, then lowest-index exception
// bit, then ERTN. ECODE/ESUBCODE are only meaningful when o_is_excp is set.
module excp_prio_enc
  import excp_commit_ctrl_pkg::*;
#(
  parameter int EXCP_W = 7
) (
  input  logic              i_has_int,
  input  logic [EXCP_W-1:0] i_excp_vec,
  input  logic              i_ertn,
  output logic              o_is_excp,
  output logic              o_is_ertn,
  output logic [5:0]        o_ecode,
  output logic [8:0]        o_esubcode
);

  always_comb begin
    o_is_excp  = 1'b1;
    o_is_ertn  = 1'b0;
    o_ecode    = ECODE_INT;
    o_esubcode = ESUB_NONE;
    if (i_has_int) begin
      o_ecode = ECODE_INT;
    end else if (i_excp_vec[EXCP_ADEF]) begin
      o_ecode    = ECODE_ADE;
      o_esubcode = ESUB_ADEF;
    end else if (i_excp_vec[EXCP_INE]) begin
      o_ecode = ECODE_INE;
    end else if (i_excp_vec[EXCP_IPE]) begin
      o_ecode = ECODE_IPE;
    end else if (i_excp_vec[EXCP_SYS]) begin
      o_ecode = ECODE_SYS;
    end else if (i_excp_vec[EXCP_BRK]) begin
      o_ecode = ECODE_BRK;
    end else if (i_excp_vec[EXCP_ALE]) begin
      o_ecode = ECODE_ALE;
    end else if (i_excp_vec[EXCP_ADEM]) begin
      o_ecode    = ECODE_ADE;
      o_esubcode = ESUB_ADEM;
    end else begin
      // No exception: an ERTN only counts when nothing above claimed the slot.
      o_is_excp = 1'b0;
      o_is_ertn = i_ertn;
    end
  end

endmodule

// File: rtl/excp_commit_ctrl.sv
// Commit-stage exception/interrupt arbiter: turns an accepted event into CSR
// strobes, a fetch redirect and a pipe flush, then blocks commit while it drains.
module excp_commit_ctrl
  import excp_commit_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2,
  parameter int EXCP_W       = 7
) (
  input logic               clk,
  input logic               reset,
  excp_commit_ctrl_if.slave bus
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           r_state, w_nxt_state;
  logic [CNT_W-1:0] r_cnt, w_nxt_cnt;
  logic             r_excp_flush, w_nxt_excp_flush;
  logic             r_ertn_flush, w_nxt_ertn_flush;
  logic             r_redirect_valid, w_nxt_redirect_valid;
  logic             r_pipe_flush, w_nxt_pipe_flush;
  logic [31:0]      r_era, w_nxt_era;
  logic [5:0]       r_ecode, w_nxt_ecode;
  logic [8:0]       r_esub, w_nxt_esub;
  logic [31:0]      r_redirect_pc, w_nxt_redirect_pc;

  logic             w_accept;
  logic             w_is_excp;
  logic             w_is_ertn;
  logic [5:0]       w_ecode;
  logic [8:0]       w_esub;

  excp_prio_enc #(.EXCP_W(EXCP_W)) u_prio_enc (
    .i_has_int  (bus.has_int),
    .i_excp_vec (bus.wb_excp_vec),
    .i_ertn     (bus.wb_ertn),
    .o_is_excp  (w_is_excp),
    .o_is_ertn  (w_is_ertn),
    .o_ecode    (w_ecode),
    .o_esubcode (w_esub)
  );

  assign w_accept = bus.wb_valid && (r_state == ST_IDLE);

  always_comb begin
    w_nxt_state          = r_state;
    w_nxt_cnt            = r_cnt;
    w_nxt_excp_flush     = 1'b0;
    w_nxt_ertn_flush     = 1'b0;
    w_nxt_redirect_valid = 1'b0;
    w_nxt_pipe_flush     = 1'b0;
    w_nxt_era            = r_era;
    w_nxt_ecode          = r_ecode;
    w_nxt_esub           = r_esub;
    w_nxt_redirect_pc    = r_redirect_pc;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && (w_is_excp || w_is_ertn)) begin
          w_nxt_state          = ST_DRAIN;
          w_nxt_cnt            = CNT_INIT;
          w_nxt_pipe_flush     = 1'b1;
          w_nxt_redirect_valid = 1'b1;
          if (w_is_excp) begin
            w_nxt_excp_flush  = 1'b1;
            w_nxt_era         = bus.wb_pc;
            w_nxt_ecode       = w_ecode;
            w_nxt_esub        = w_esub;
            w_nxt_redirect_pc = bus.csr_eentry;
          end else begin
            w_nxt_ertn_flush  = 1'b1;
            w_nxt_redirect_pc = bus.csr_era;
          end
        end
      end
      ST_DRAIN: begin
        // pipe_flush covers the event cycle plus DRAIN_CYCLES-1 further cycles.
        if (r_cnt == '0) begin
          w_nxt_state = ST_IDLE;
        end else begin
          w_nxt_cnt        = r_cnt - CNT_ONE;
          w_nxt_pipe_flush = 1'b1;
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= ST_IDLE;
      r_cnt            <= '0;
      r_excp_flush     <= 1'b0;
      r_ertn_flush     <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_pipe_flush     <= 1'b0;
      r_era            <= '0;
      r_ecode          <= '0;
      r_esub           <= '0;
      r_redirect_pc    <= '0;
    end else begin
      r_state          <= w_nxt_state;
      r_cnt            <= w_nxt_cnt;
      r_excp_flush     <= w_nxt_excp_flush;
      r_ertn_flush     <= w_nxt_ertn_flush;
      r_redirect_valid <= w_nxt_redirect_valid;
      r_pipe_flush     <= w_nxt_pipe_flush;
      r_era            <= w_nxt_era;
      r_ecode          <= w_nxt_ecode;
      r_esub           <= w_nxt_esub;
      r_redirect_pc    <= w_nxt_redirect_pc;
    end
  end

  assign bus.wb_ready       = (r_state == ST_IDLE);
  assign bus.excp_flush     = r_excp_flush;
  assign bus.ertn_flush     = r_ertn_flush;
  assign bus.redirect_valid = r_redirect_valid;
  assign bus.pipe_flush     = r_pipe_flush;
  assign bus.era_out        = r_era;
  assign bus.ecode_out      = r_ecode;
  assign bus.esubcode_out   = r_esub;
  assign bus.redirect_pc    = r_redirect_pc;
  assign bus.dbg_state      = r_state;

endmodule
